vgm_apb_tri_master_ctrl: RTL

- APB master controller that shares one APB bus with a tri-state PDATA between NUM_REQ local requesters.
- Round-robin arbitrates pending requests and sequences the SETUP/ACCESS phases.
- Drives PDATA only during write transfers and returns read data, or a timeout error, to the winning requester.
- Sits between on-chip requesters (register sequencers, DMA-like agents) and the vgm_apb_tri bus.

---
 rtl/vgm_apb_tri_pkg.sv | 30 +++
 rtl/vgm_apb_tri_master_ctrl_if.sv | 36 +++
 rtl/vgm_apb_tri_rr_arbiter.sv | 32 +++
 rtl/vgm_apb_tri_master_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/vgm_apb_tri_pkg.sv
// Shared types, default widths and round-robin grant helper for the APB tri-state master.
package vgm_apb_tri_pkg;

   localparam int unsigned DefAddrW = 32;
   localparam int unsigned DefDataW = 32;
   localparam int unsigned MaxReq   = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_e;

   // One-hot grant of the first set request at or after ptr, wrapping modulo n.
   function automatic logic [MaxReq-1:0] rr_grant(input logic [MaxReq-1:0] req,
                                                  input int unsigned       ptr,
                                                  input int unsigned       n);
      logic [MaxReq-1:0] gnt;
      int unsigned       idx;
      gnt = '0;
      for (int unsigned k = 0; k < n; k++) begin
         idx = (ptr + k) % n;
         if (req[idx[2:0]] && (gnt == '0)) begin
            gnt[idx[2:0]] = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/vgm_apb_tri_master_ctrl_if.sv
// Requester handshake and APB control signals; PDATA stays a plain inout on the controller.
interface vgm_apb_tri_master_ctrl_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
);
   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic                      rsp_valid;
   logic [IdxW-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_error;
   logic                      PSEL;
   logic                      PENABLE;
   logic                      PWRITE;
   logic [ADDR_W-1:0]         PADDR;
   logic                      PREADY;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, PREADY,
      output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_error,
      output PSEL, PENABLE, PWRITE, PADDR
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, PREADY,
      input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_error,
      input  PSEL, PENABLE, PWRITE, PADDR
   );

endinterface

// File: rtl/vgm_apb_tri_rr_arbiter.sv
// Combinational round-robin arbiter: priority starts at ptr_i and wraps.
module vgm_apb_tri_rr_arbiter
   import vgm_apb_tri_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdxW-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IdxW-1:0]    idx_o,
   output logic               valid_o
);

   logic [MaxReq-1:0] req_ext;
   logic [MaxReq-1:0] gnt_ext;

   // Rotate-and-pick grant, then encode the one-hot grant to an index.
   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = req_i;
      gnt_ext                = rr_grant(req_ext, 32'(ptr_i), NUM_REQ);
      gnt_o                  = gnt_ext[NUM_REQ-1:0];
      idx_o                  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_ext[i]) idx_o = IdxW'(i);
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/vgm_apb_tri_master_ctrl.sv
// APB master sharing a tri-state PDATA bus among NUM_REQ round-robin requesters.
module vgm_apb_tri_master_ctrl
   import vgm_apb_tri_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   vgm_apb_tri_master_ctrl_if.master bus,
   inout  wire  [DATA_W-1:0]         PDATA
);

   localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned WaitW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     ptr_q, ptr_d;
   logic [IdxW-1:0]     id_q, id_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                write_q, write_d;
   logic [WaitW-1:0]    wait_q, wait_d, wait_inc;
   logic                pdata_oe_q, pdata_oe_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_error_q, rsp_error_d;
   logic [IdxW-1:0]     rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [IdxW-1:0]     arb_idx;
   logic                arb_valid;
   logic                timeout_hit;

   vgm_apb_tri_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   assign wait_inc    = wait_q + 1'b1;
   // PREADY on the same edge takes precedence; this only aborts a still-waiting access.
   assign timeout_hit = (TIMEOUT != 0) && (32'(wait_inc) == TIMEOUT);

   // FSM state register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (arb_valid) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (bus.PREADY || timeout_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state: request latch, pointer, wait counter, response and PDATA enable.
   always_comb begin
      ptr_d       = ptr_q;
      id_d        = id_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      write_d     = write_q;
      wait_d      = wait_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_rdata_d = rsp_rdata_q;
      if ((state_q == IDLE) && arb_valid) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
               addr_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
               wdata_d = bus.req_wdata[i*DATA_W +: DATA_W];
               write_d = bus.req_write[i];
            end
         end
         id_d  = arb_idx;
         ptr_d = (arb_idx == IdxW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (state_q == SETUP) wait_d = '0;
      if (state_q == ACCESS) begin
         if (bus.PREADY) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_rdata_d = write_q ? '0 : PDATA;
         end else if (timeout_hit) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_rdata_d = '0;
         end else begin
            wait_d = wait_inc;
         end
      end
      // Registered copy of PSEL & PWRITE for the coming cycle.
      pdata_oe_d = write_d && ((state_d == SETUP) || (state_d == ACCESS));
   end

   // Datapath registers.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ptr_q       <= '0;
         id_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         wait_q      <= '0;
         pdata_oe_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rdata_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         wait_q      <= wait_d;
         pdata_oe_q  <= pdata_oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // FSM outputs: APB phase control and the accept strobe.
   always_comb begin
      bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
      bus.PENABLE   = (state_q == ACCESS);
      bus.PWRITE    = write_q && (state_q != IDLE);
      bus.req_ready = (state_q == IDLE) ? arb_gnt : '0;
   end

   assign bus.PADDR     = addr_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_error = rsp_error_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign PDATA         = pdata_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule
